s_div32: RTL
============

Name: s_div32

Overview:
- Sequential signed 32-bit integer divider; inverse companion to the signed Booth multiplier, with the same start/done handshake and the same clk/n_rst convention.
- Radix-2 restoring division on operand magnitudes, followed by one sign-correction step.
- Quotient truncates toward zero; remainder takes the dividend's sign.
- Sits beside the multiplier in the arithmetic unit and is driven by the same controller.

Parameters:
- WIDTH, 32, operand/result width in bits. Iteration count equals WIDTH. Only 32 is verified.

Ports:
- clk  input  1  rising-edge clock
- n_rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- src1  input  WIDTH  dividend, two's complement; sampled with start
- src2  input  WIDTH  divisor, two's complement; sampled with start
- quotient  output  WIDTH  signed quotient, registered
- remainder  output  WIDTH  signed remainder, registered
- div_by_zero  output  1  set with done when src2 was 0; holds until next done
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse marking valid results

Behaviour:
- Reset: async on n_rst=0. State becomes IDLE. quotient, remainder, div_by_zero, busy and done are all 0. The iteration counter and internal registers are cleared.
- Reset mid-operation: the operation is abandoned and no done pulse is produced. The first start after n_rst rises is accepted normally.
- FSM states: IDLE, CALC, FIX.
- IDLE, on an edge E0 with start=1:
  - latch |src1|, |src2|, sign_q = src1[31]^src2[31], sign_r = src1[31], and a zero flag (src2==0);
  - clear the partial remainder (WIDTH+1 bits) and the counter;
  - busy goes to 1; next state is CALC.
  - With start=0, IDLE holds.
- CALC, edges E1..E32, one quotient bit per edge, MSB first:
  - shift {partial remainder, dividend} left by 1;
  - trial subtract the divisor magnitude;
  - if the result is non-negative, keep it and set quotient bit 1; otherwise restore and set 0.
  - After the 32nd iteration, next state is FIX.
- FIX, edge E33:
  - quotient = sign_q ? -q_mag : q_mag
  - remainder = sign_r ? -r_mag : r_mag
  - done=1 and busy=0 (both registered); next state is IDLE.
- done is high exactly in the cycle between E33 and E34. Latency from the start-sampling edge to done high is 33 clocks.
- Back-to-back: start can be accepted at E34, when the FSM is back in IDLE.
- start while busy (CALC/FIX): ignored, no effect on the operation in flight. src1/src2 may change freely after E0.
- Magnitude of -2^31: treated as unsigned 2^31 (no overflow inside the 32-bit magnitude path).
- Divide by zero:
  - the full latency still applies;
  - quotient = 32'hFFFF_FFFF, remainder = src1 (original signed value), div_by_zero=1.
  - The sign correction is bypassed for this case.
- Overflow (-2^31 / -1): quotient = 32'h8000_0000, remainder = 0, div_by_zero=0. This falls out of the natural magnitude math plus negation wrap; no special casing is needed, but it must be verified.
- Results and div_by_zero hold their values until the next FIX. They are not cleared by start.
- Invariant for all non-zero divisors: src1 == quotient*src2 + remainder (mod 2^32), and |remainder| < |src2|.

Test Plan:
1. Reset, then src1=100, src2=7, start for 1 cycle -> done after 33 clocks; quotient=14, remainder=2, div_by_zero=0; busy high during the 32 CALC cycles and FIX.
2. Sign combinations:
   - -100/7 -> q=-14 (32'hFFFF_FFF2), r=-2 (32'hFFFF_FFFE);
   - 100/-7 -> q=-14, r=2;
   - -100/-7 -> q=14, r=-2.
3. Boundaries:
   - 32'h8000_0000/32'hFFFF_FFFF -> q=32'h8000_0000, r=0;
   - 32'h8000_0000/1 -> q=32'h8000_0000, r=0;
   - 5/0 -> q=32'hFFFF_FFFF, r=5, div_by_zero=1;
   - 0/-3 -> q=0, r=0.
4. Handshake:
   - pulse start again at cycles 5 and 20 of an operation (30/4) with different operands -> result is still q=7, r=2, and only one done pulse;
   - a new start at E34 is accepted, and its done arrives 33 clocks later.
5. Reset mid-operation: drop n_rst at CALC iteration 10 -> outputs go to 0 asynchronously, no done pulse; the next operation 1000/33 -> q=30, r=10.
6. Random: 200 pairs from $urandom, including negatives and small divisors -> check the invariant and compare against the $signed `/` and `%` operators; zero divisors are checked against the div-by-zero rule.

Source files
------------

// File: rtl/s_div32.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// then one sign-correction cycle. Quotient truncates toward zero; remainder follows the dividend.
module s_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                   state_q, state_d;
  logic        [WIDTH-1:0]  dvd_q, dvd_d;     // dividend magnitude, becomes quotient magnitude
  logic        [WIDTH-1:0]  dvs_q, dvs_d;     // divisor magnitude
  logic        [WIDTH-1:0]  rem_q, rem_d;     // partial remainder (always < divisor)
  logic        [WIDTH-1:0]  src1_q, src1_d;   // original dividend for the divide-by-zero result
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic                     sgn_q_q, sgn_q_d;
  logic                     sgn_r_q, sgn_r_d;
  logic                     zero_q, zero_d;
  logic        [WIDTH-1:0]  quot_q, quot_d;
  logic        [WIDTH-1:0]  remo_q, remo_d;
  logic                     dbz_q, dbz_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic        [WIDTH:0]    rem_sh;

  // Magnitude of a two's-complement value; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    src1_d  = src1_q;
    cnt_d   = cnt_q;
    sgn_q_d = sgn_q_q;
    sgn_r_d = sgn_r_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rem_sh  = {rem_q, dvd_q[WIDTH-1]};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = magnitude(src1);
          dvs_d   = magnitude(src2);
          src1_d  = src1;
          sgn_q_d = src1[WIDTH-1] ^ src2[WIDTH-1];
          sgn_r_d = src1[WIDTH-1];
          zero_d  = (src2 == '0);
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d = WIDTH'(rem_sh - {1'b0, dvs_q});
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        // A zero divisor bypasses sign correction and returns the dividend unchanged.
        if (zero_q) begin
          quot_d = '1;
          remo_d = src1_q;
        end else begin
          quot_d = apply_sign(dvd_q, sgn_q_q);
          remo_d = apply_sign(rem_q, sgn_r_q);
        end
        dbz_d   = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      src1_q  <= '0;
      cnt_q   <= '0;
      sgn_q_q <= 1'b0;
      sgn_r_q <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      src1_q  <= src1_d;
      cnt_q   <= cnt_d;
      sgn_q_q <= sgn_q_d;
      sgn_r_q <= sgn_r_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
